// File: rtl/adc_fifo_drain_scheduler.sv
// Round-robin drain of per-channel ADC sample FIFOs onto a channel-tagged valid/ready stream.
// Optional ADC_SCHED_TIMESTAMP_EN adds m_timestamp, a free-running count sampled in the READ cycle.
module adc_fifo_drain_scheduler #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_WIDTH      = 12,
    parameter int BURST_LEN       = 8,
    parameter int FIFO_RD_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_CHANNELS-1:0]         ch_mask,
    output logic [$clog2(NUM_CHANNELS)-1:0] fifo_addr,
    output logic [NUM_CHANNELS-1:0]         fifo_rd_en,
    input  logic                            fifo_not_empty,
    input  logic                            fifo_full,
    input  logic [DATA_WIDTH-1:0]           fifo_dout,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [$clog2(NUM_CHANNELS)-1:0] m_chan,
    output logic                            m_valid,
    input  logic                            m_ready,
`ifdef ADC_SCHED_TIMESTAMP_EN
    output logic [31:0]                     m_timestamp,
`endif
    output logic [NUM_CHANNELS-1:0]         overflow,
    input  logic [NUM_CHANNELS-1:0]         overflow_clr,
    output logic                            busy
);
    localparam int CH_W   = $clog2(NUM_CHANNELS);
    localparam int BC_W   = $clog2(BURST_LEN + 1);
    localparam int WAIT_W = (FIFO_RD_LATENCY > 1) ? $clog2(FIFO_RD_LATENCY) : 1;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [BC_W-1:0]   BURST_MAX = BC_W'(BURST_LEN);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FIFO_RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_SELECT,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t                  state_reg, state_next;
    logic [CH_W-1:0]         ptr_reg, ptr_next;
    logic [BC_W-1:0]         burst_cnt_reg, burst_cnt_next;
    logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
    logic [DATA_WIDTH-1:0]   m_data_reg, m_data_next;
    logic [CH_W-1:0]         m_chan_reg, m_chan_next;
    logic                    m_valid_reg, m_valid_next;
    logic [NUM_CHANNELS-1:0] overflow_reg;
    logic [NUM_CHANNELS-1:0] overflow_set;
    logic [CH_W-1:0]         ptr_inc;
    logic [BC_W-1:0]         burst_inc;

    // Explicit wrap so non-power-of-two channel counts never alias through bit overflow.
    assign ptr_inc   = (ptr_reg == LAST_CH) ? '0 : ptr_reg + 1'b1;
    assign burst_inc = burst_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        m_data_next    = m_data_reg;
        m_chan_next    = m_chan_reg;
        m_valid_next   = m_valid_reg;
        case (state_reg)
            S_SELECT: state_next = S_CHECK;
            S_CHECK: begin
                if (enable && ch_mask[ptr_reg] && fifo_not_empty) begin
                    state_next = S_READ;
                end else begin
                    ptr_next       = ptr_inc;
                    burst_cnt_next = '0;
                    state_next     = S_SELECT;
                end
            end
            S_READ: begin
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    m_data_next  = fifo_dout;
                    m_chan_next  = ptr_reg;
                    m_valid_next = 1'b1;
                    state_next   = S_OUTPUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_OUTPUT: begin
                // m_valid is always high here, so m_ready alone completes the handshake.
                if (m_ready) begin
                    m_valid_next   = 1'b0;
                    burst_cnt_next = burst_inc;
                    if (burst_inc < BURST_MAX && enable && ch_mask[ptr_reg]) begin
                        state_next = S_CHECK;
                    end else begin
                        ptr_next       = ptr_inc;
                        burst_cnt_next = '0;
                        state_next     = S_SELECT;
                    end
                end
            end
            default: state_next = S_SELECT;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            assign fifo_rd_en[gi]   = (state_reg == S_READ) && (ptr_reg == CH_W'(gi));
            assign overflow_set[gi] = (state_reg != S_SELECT) && fifo_full && (ptr_reg == CH_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_SELECT;
            ptr_reg       <= '0;
            burst_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            m_data_reg    <= '0;
            m_chan_reg    <= '0;
            m_valid_reg   <= 1'b0;
            overflow_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            m_data_reg    <= m_data_next;
            m_chan_reg    <= m_chan_next;
            m_valid_reg   <= m_valid_next;
            // Set is applied after clear so a coincident set wins.
            overflow_reg  <= (overflow_reg & ~overflow_clr) | overflow_set;
        end
    end

`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [31:0] ts_cnt_reg;
    logic [31:0] ts_sample_reg;
    logic [31:0] m_timestamp_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_reg      <= '0;
            ts_sample_reg   <= '0;
            m_timestamp_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 32'd1;
            if (state_reg == S_READ) begin
                ts_sample_reg <= ts_cnt_reg;
            end
            if (state_reg == S_WAIT && wait_cnt_reg == WAIT_LAST) begin
                m_timestamp_reg <= ts_sample_reg;
            end
        end
    end

    assign m_timestamp = m_timestamp_reg;
`endif

    // The FIFO mux select follows ptr, which only moves on entry to SELECT.
    assign fifo_addr = ptr_reg;
    assign m_data    = m_data_reg;
    assign m_chan    = m_chan_reg;
    assign m_valid   = m_valid_reg;
    assign overflow  = overflow_reg;
    assign busy      = (state_reg != S_SELECT) && (state_reg != S_CHECK);

endmodule

// File: tb/tb_adc_fifo_drain_scheduler.sv
// Bench for adc_fifo_drain_scheduler: behavioural FIFO model, stream scoreboard,
// a polling/overflow vector table and directed multi-cycle sequences.
module tb_adc_fifo_drain_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [1:0]  fifo_addr;
    logic [3:0]  fifo_rd_en;
    logic        fifo_not_empty;
    logic        fifo_full;
    logic [11:0] fifo_dout;
    logic [11:0] m_data;
    logic [1:0]  m_chan;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  overflow;
    logic [3:0]  overflow_clr;
    logic        busy;
`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [31:0] m_timestamp;
`endif

    always #5 clk = ~clk;

    adc_fifo_drain_scheduler dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .fifo_addr(fifo_addr), .fifo_rd_en(fifo_rd_en),
        .fifo_not_empty(fifo_not_empty), .fifo_full(fifo_full), .fifo_dout(fifo_dout),
        .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
`ifdef ADC_SCHED_TIMESTAMP_EN
        .m_timestamp(m_timestamp),
`endif
        .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
    );

    // Behavioural per-channel FIFOs with one cycle of read latency.
    logic [11:0] mem [4][64];
    int          wr_cnt [4] = '{0, 0, 0, 0};
    int          rd_cnt [4] = '{0, 0, 0, 0};
    logic [11:0] dout_q [4] = '{12'h0, 12'h0, 12'h0, 12'h0};
    logic [3:0]  full_vec;
    int          underflow = 0;
    int          cyc = 0;

    assign fifo_not_empty = (wr_cnt[fifo_addr] != rd_cnt[fifo_addr]);
    assign fifo_dout      = dout_q[fifo_addr];
    assign fifo_full      = full_vec[fifo_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int c = 0; c < 4; c++) begin
            if (fifo_rd_en[c]) begin
                if (rd_cnt[c] == wr_cnt[c]) begin
                    underflow <= underflow + 1;
                end else begin
                    dout_q[c] <= mem[c][rd_cnt[c] % 64];
                    rd_cnt[c] <= rd_cnt[c] + 1;
                end
            end
        end
    end

    // Stream scoreboard: every handshake is recorded in order.
    logic [11:0] cap_data [$];
    logic [1:0]  cap_chan [$];
    always @(posedge clk) begin
        if (m_valid && m_ready) begin
            cap_data.push_back(m_data);
            cap_chan.push_back(m_chan);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int ch, input logic [11:0] d);
        mem[ch][wr_cnt[ch] % 64] = d;
        wr_cnt[ch] = wr_cnt[ch] + 1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_rd();
        int n = 0;
        while (fifo_rd_en == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_caps(input int target);
        int n = 0;
        while (cap_data.size() < target && n < 800) begin
            @(negedge clk);
            n++;
        end
        check("handshake_count", cap_data.size(), target);
    endtask

    task automatic check_cap(input string name, input int idx, input logic [1:0] ch, input logic [11:0] d);
        if (idx < cap_data.size()) begin
            check(name, {cap_chan[idx], cap_data[idx]}, {ch, d});
        end else begin
            check(name, 32'hFFFF_FFFF, {ch, d});
        end
    endtask

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [3:0] full;
        logic [3:0] clr;
        logic [1:0] exp_addr;
        logic [3:0] exp_ovf;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [18];
        logic [11:0] t2d [3];
        int          base;
        int          prev;
        int          n;
        int          reads;
        logic [1:0]  ech;
        int          k;

        // Each row: inputs held for one cycle, outputs expected after that edge.
        // All FIFOs empty, so the scheduler polls two cycles per channel.
        tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd1, 4'h0};
        tbl[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd1, 4'h0};
        tbl[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd2, 4'h0};
        tbl[4]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd2, 4'h0};
        tbl[5]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd3, 4'h0};
        tbl[6]  = '{1'b1, 4'hF, 4'h8, 4'h0, 2'd3, 4'h0};  // full during SELECT: ignored
        tbl[7]  = '{1'b1, 4'hF, 4'h8, 4'h0, 2'd0, 4'h8};  // full during CHECK ch3: set
        tbl[8]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 4'h8};  // sticky
        tbl[9]  = '{1'b1, 4'hF, 4'h0, 4'h8, 2'd1, 4'h0};  // cleared
        tbl[10] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd1, 4'h0};
        tbl[11] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd2, 4'h0};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 2'd2, 4'h0};
        tbl[13] = '{1'b1, 4'h0, 4'h0, 4'h0, 2'd3, 4'h0};
        tbl[14] = '{1'b1, 4'hF, 4'h8, 4'h0, 2'd3, 4'h0};
        tbl[15] = '{1'b1, 4'hF, 4'h9, 4'h8, 2'd0, 4'h8};  // set and clear together: set wins
        tbl[16] = '{1'b1, 4'h5, 4'h0, 4'h0, 2'd0, 4'h8};
        tbl[17] = '{1'b1, 4'h5, 4'h0, 4'h8, 2'd1, 4'h0};

        rst = 1'b1; enable = 1'b0; ch_mask = 4'h0; m_ready = 1'b1;
        overflow_clr = 4'h0; full_vec = 4'h0;
        tick(2);
        check("reset_outputs", {m_valid, fifo_addr, busy, fifo_rd_en, m_data, m_chan, overflow}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            enable = tbl[i].en; ch_mask = tbl[i].mask;
            full_vec = tbl[i].full; overflow_clr = tbl[i].clr;
            @(negedge clk);
            check($sformatf("poll_addr[%0d]", i), fifo_addr, tbl[i].exp_addr);
            check($sformatf("poll_ovf[%0d]", i), overflow, tbl[i].exp_ovf);
            check($sformatf("poll_idle[%0d]", i), {busy, fifo_rd_en, m_valid}, 32'h0);
        end
        enable = 1'b1; ch_mask = 4'hF; full_vec = 4'h0; overflow_clr = 4'h0;

        // Ch2 holds three samples: single-cycle strobes four cycles apart.
        t2d[0] = 12'h111; t2d[1] = 12'h222; t2d[2] = 12'h333;
        base = cap_data.size();
        for (int i = 0; i < 3; i++) load(2, t2d[i]);
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_rd();
            check("t2_rd_en", fifo_rd_en, 4'b0100);
            if (i > 0) check("t2_gap", cyc - prev, 4);
            prev = cyc;
            tick(1);
            check("t2_rd_single", fifo_rd_en, 4'b0000);
            tick(1);
            check("t2_out", {m_valid, m_chan, m_data}, {1'b1, 2'd2, t2d[i]});
        end
        tick(2);
        check("t2_ptr_next", fifo_addr, 2'd3);
        for (int i = 0; i < 3; i++) check_cap("t2_stream", base + i, 2'd2, t2d[i]);

        // Ch0 and ch1 with ten samples each: bursts of 8 then 2, alternating.
        base = cap_data.size();
        for (int i = 0; i < 10; i++) begin
            load(0, 12'h100 + 12'(i));
            load(1, 12'h200 + 12'(i));
        end
        wait_caps(base + 20);
        for (int i = 0; i < 20; i++) begin
            if (i < 8)       begin ech = 2'd0; k = i;      end
            else if (i < 16) begin ech = 2'd1; k = i - 8;  end
            else if (i < 18) begin ech = 2'd0; k = i - 8;  end
            else             begin ech = 2'd1; k = i - 10; end
            check_cap($sformatf("t3_stream[%0d]", i), base + i, ech,
                      (ech == 2'd0 ? 12'h100 : 12'h200) + 12'(k));
        end

        // Backpressure: output held stable and no further reads while m_ready is low.
        m_ready = 1'b0;
        base = cap_data.size();
        load(2, 12'hABC);
        load(2, 12'hDEF);
        n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_valid_seen", m_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t4_hold", {m_valid, m_chan, m_data, fifo_rd_en, busy},
                  {1'b1, 2'd2, 12'hABC, 4'b0000, 1'b1});
        end
        m_ready = 1'b1;
        wait_caps(base + 2);
        check_cap("t4_stream0", base, 2'd2, 12'hABC);
        check_cap("t4_stream1", base + 1, 2'd2, 12'hDEF);

        // Reset during WAIT discards the in-flight sample.
        load(1, 12'h5A5);
        wait_rd();
        check("t6_rd_en", fifo_rd_en, 4'b0010);
        tick(1);
        check("t6_busy_wait", busy, 1'b1);
        base = cap_data.size();
        rst = 1'b1;
        tick(1);
        check("t6_after_rst", {m_valid, fifo_addr, busy, fifo_rd_en, m_data, m_chan, overflow}, 32'h0);
        rst = 1'b0;
        tick(1);
        check("t6_check0", {fifo_addr, busy}, {2'd0, 1'b0});
        tick(1);
        check("t6_select1", fifo_addr, 2'd1);
        tick(20);
        check("t6_no_delivery", cap_data.size(), base);

        // Enable dropped mid-burst: current sample delivered, then no reads.
        base = cap_data.size();
        for (int i = 0; i < 4; i++) load(2, 12'h701 + 12'(i));
        wait_rd();
        check("t7_rd_en", fifo_rd_en, 4'b0100);
        tick(1);
        enable = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t7_out", {m_valid, m_chan, m_data}, {1'b1, 2'd2, 12'h701});
        reads = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (fifo_rd_en != 4'b0) reads++;
        end
        check("t7_parked_reads", reads, 0);
        check("t7_one_delivered", cap_data.size(), base + 1);
        enable = 1'b1;
        wait_caps(base + 4);
        for (int i = 0; i < 4; i++) check_cap("t7_stream", base + i, 2'd2, 12'h701 + 12'(i));

        tick(4);
        check("fifo_underflow", underflow, 0);
        for (int c = 0; c < 4; c++) check($sformatf("fifo_drained[%0d]", c), rd_cnt[c], wr_cnt[c]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
